// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle control unit that fetches 8-bit instructions,
// decodes the opcode and sequences the external PC, accumulator, flag register,
// register file and ALU through combinational strobes.
//
// Build option: define ILLEGAL_TRAP_EN so that an illegal opcode traps to HALT
// with a sticky illegal flag. When it is undefined, an illegal opcode behaves as
// a NOP and illegal pulses for the single DECODE cycle.
//
// Memory handshake: mem_rd requests a read at the external PC. instr_in is valid
// only in a cycle where mem_ready=1, and the transfer completes in that cycle.
// mem_rd stays high in every FETCH/OPER cycle, including the accepting one.
module cpu_control_fsm #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] instr_in,
    input  logic              mem_ready,
    input  logic              z_in,
    input  logic              c_in,
    output logic              mem_rd,
    output logic              ir_load,
    output logic              pc_inc,
    output logic              pc_load,
    output logic [3:0]        alu_sel,
    output logic              acc_load,
    output logic              flag_load,
    output logic              reg_we,
    output logic [3:0]        reg_addr,
    output logic [DATA_W-1:0] ir_out,
    output logic              illegal,
    output logic              bus_err,
    output logic              halted,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_OPER   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_MOVR = 4'b0100;
    localparam logic [3:0] OP_MOVA = 4'b0101;
    localparam logic [3:0] OP_JZ   = 4'b0110;
    localparam logic [3:0] OP_JC   = 4'b0111;
    localparam logic [3:0] OP_JMP  = 4'b1000;
    localparam logic [3:0] OP_SHL  = 4'b1011;
    localparam logic [3:0] OP_SHR  = 4'b1100;
    localparam logic [3:0] OP_HALT = 4'b1111;

    // The wait counter holds the number of wait cycles already spent; the
    // cycle that sees LAST without mem_ready is the TIMEOUT-th wait.
    localparam int            CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                bus_err_q, bus_err_d;
    logic [3:0]          opcode;

    logic                mem_rd_c, ir_load_c, pc_inc_c, pc_load_c;
    logic                acc_load_c, flag_load_c, reg_we_c, dec_illegal;
    logic [3:0]          alu_sel_c;
    logic                taken;

`ifdef ILLEGAL_TRAP_EN
    logic                illegal_q, illegal_d;
`endif

    assign opcode = ir_q[DATA_W-1 -: 4];

    // Next-state, datapath-register updates and raw strobes.
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        cnt_d       = cnt_q;
        bus_err_d   = bus_err_q;
`ifdef ILLEGAL_TRAP_EN
        illegal_d   = illegal_q;
`endif
        mem_rd_c    = 1'b0;
        ir_load_c   = 1'b0;
        pc_inc_c    = 1'b0;
        pc_load_c   = 1'b0;
        alu_sel_c   = 4'b0000;
        acc_load_c  = 1'b0;
        flag_load_c = 1'b0;
        reg_we_c    = 1'b0;
        dec_illegal = 1'b0;
        taken       = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_rd_c = 1'b1;
                if (mem_ready) begin
                    ir_load_c = 1'b1;
                    pc_inc_c  = 1'b1;
                    ir_d      = instr_in;
                    state_d   = S_DECODE;
                end else if (cnt_q == LAST) begin
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_NOR, OP_MOVR,
                    OP_SHL, OP_SHR, OP_MOVA:  state_d = S_EXEC;
                    OP_JZ, OP_JC, OP_JMP:     state_d = S_OPER;
                    OP_NOP:                   state_d = S_FETCH;
                    OP_HALT:                  state_d = S_HALT;
                    default: begin
                        dec_illegal = 1'b1;
`ifdef ILLEGAL_TRAP_EN
                        illegal_d   = 1'b1;
                        state_d     = S_HALT;
`else
                        state_d     = S_FETCH;
`endif
                    end
                endcase
            end
            S_EXEC: begin
                alu_sel_c = opcode;
                if (opcode == OP_MOVA) begin
                    reg_we_c = 1'b1;
                end else begin
                    acc_load_c  = 1'b1;
                    flag_load_c = 1'b1;
                end
                state_d = S_FETCH;
            end
            S_OPER: begin
                mem_rd_c = 1'b1;
                if (mem_ready) begin
                    taken = (opcode == OP_JMP) ||
                            ((opcode == OP_JZ) && z_in) ||
                            ((opcode == OP_JC) && c_in);
                    pc_load_c = taken;
                    pc_inc_c  = ~taken;
                    state_d   = S_FETCH;
                end else if (cnt_q == LAST) begin
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // A completed transfer or any state change restarts the wait count.
        if (mem_ready || (state_d != state_q)) begin
            cnt_d = '0;
        end
    end

    // State and sticky-register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    // Strobes are suppressed in any reset cycle so an abandoned instruction
    // cannot disturb the external PC, accumulator or register file.
    assign mem_rd    = mem_rd_c    & ~rst;
    assign ir_load   = ir_load_c   & ~rst;
    assign pc_inc    = pc_inc_c    & ~rst;
    assign pc_load   = pc_load_c   & ~rst;
    assign acc_load  = acc_load_c  & ~rst;
    assign flag_load = flag_load_c & ~rst;
    assign reg_we    = reg_we_c    & ~rst;
    assign alu_sel   = rst ? 4'b0000 : alu_sel_c;

    assign reg_addr  = ir_q[3:0];
    assign ir_out    = ir_q;
    assign bus_err   = bus_err_q;
    assign halted    = (state_q == S_HALT);
    assign state_dbg = state_q;

`ifdef ILLEGAL_TRAP_EN
    assign illegal = illegal_q | (dec_illegal & ~rst);
`else
    assign illegal = dec_illegal & ~rst;
`endif

endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb_cpu_control_fsm: directed, table-driven bench for cpu_control_fsm.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_cpu_control_fsm;

    logic       clk;
    logic       rst;
    logic [7:0] instr_in;
    logic       mem_ready;
    logic       z_in;
    logic       c_in;
    logic       mem_rd, ir_load, pc_inc, pc_load;
    logic [3:0] alu_sel;
    logic       acc_load, flag_load, reg_we;
    logic [3:0] reg_addr;
    logic [7:0] ir_out;
    logic       illegal, bus_err, halted;
    logic [2:0] state_dbg;

    int n_checks = 0;
    int n_err    = 0;

    cpu_control_fsm #(.DATA_W(8), .TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .instr_in  (instr_in),
        .mem_ready (mem_ready),
        .z_in      (z_in),
        .c_in      (c_in),
        .mem_rd    (mem_rd),
        .ir_load   (ir_load),
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .alu_sel   (alu_sel),
        .acc_load  (acc_load),
        .flag_load (flag_load),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .ir_out    (ir_out),
        .illegal   (illegal),
        .bus_err   (bus_err),
        .halted    (halted),
        .state_dbg (state_dbg)
    );

    // Clock and initial input levels.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic [7:0]  instr;
        logic        rdy;
        logic        z;
        logic        c;
        logic [25:0] exp;
    } vec_t;

    // Expected output word: {mem_rd, ir_load, pc_inc, pc_load, alu_sel,
    // acc_load, flag_load, reg_we, reg_addr, ir_out, illegal, bus_err, halted}
    function automatic vec_t mkv(
        input logic r, input logic [7:0] ins, input logic rd, input logic zz, input logic cc,
        input logic mrd, input logic irl, input logic pci, input logic pcl,
        input logic [3:0] alu, input logic acc, input logic flg, input logic rwe,
        input logic [3:0] ra, input logic [7:0] iro,
        input logic ill, input logic berr, input logic hlt);
        vec_t v;
        v.rst   = r;
        v.instr = ins;
        v.rdy   = rd;
        v.z     = zz;
        v.c     = cc;
        v.exp   = {mrd, irl, pci, pcl, alu, acc, flg, rwe, ra, iro, ill, berr, hlt};
        return v;
    endfunction

    function automatic logic [25:0] outs();
        return {mem_rd, ir_load, pc_inc, pc_load, alu_sel, acc_load, flag_load,
                reg_we, reg_addr, ir_out, illegal, bus_err, halted};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver: apply one cycle of inputs on the falling edge, settle 1 ns.
    task automatic step(input logic r, input logic [7:0] ins, input logic rd,
                        input logic zz, input logic cc);
        @(negedge clk);
        rst       = r;
        instr_in  = ins;
        mem_ready = rd;
        z_in      = zz;
        c_in      = cc;
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        rst = 1'b1; instr_in = 8'h00; mem_ready = 1'b0; z_in = 1'b0; c_in = 1'b0;

        //            rst ins  rdy z c   mrd irl pci pcl alu  acc flg rwe ra    ir    ill be hl
        vecs.push_back(mkv(1, 8'h00, 0, 0, 0,  0, 0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 8'h00, 0, 0, 0)); // reset state
        vecs.push_back(mkv(0, 8'h15, 1, 0, 0,  1, 1, 1, 0, 4'h0, 0, 0, 0, 4'h0, 8'h00, 0, 0, 0)); // fetch ADD r5
        vecs.push_back(mkv(0, 8'h00, 0, 0, 0,  0, 0, 0, 0, 4'h0, 0, 0, 0, 4'h5, 8'h15, 0, 0, 0)); // decode
        vecs.push_back(mkv(0, 8'h00, 0, 0, 0,  0, 0, 0, 0, 4'h1, 1, 1, 0, 4'h5, 8'h15, 0, 0, 0)); // exec ADD
        vecs.push_back(mkv(0, 8'h55, 1, 0, 0,  1, 1, 1, 0, 4'h0, 0, 0, 0, 4'h5, 8'h15, 0, 0, 0)); // fetch MOVA r5
        vecs.push_back(mkv(0, 8'h00, 0, 0, 0,  0, 0, 0, 0, 4'h0, 0, 0, 0, 4'h5, 8'h55, 0, 0, 0));
        vecs.push_back(mkv(0, 8'h00, 0, 0, 0,  0, 0, 0, 0, 4'h5, 0, 0, 1, 4'h5, 8'h55, 0, 0, 0)); // exec MOVA
        vecs.push_back(mkv(0, 8'h00, 1, 0, 0,  1, 1, 1, 0, 4'h0, 0, 0, 0, 4'h5, 8'h55, 0, 0, 0)); // fetch NOP
        vecs.push_back(mkv(0, 8'h00, 0, 0, 0,  0, 0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 8'h00, 0, 0, 0)); // decode NOP
        vecs.push_back(mkv(0, 8'h63, 1, 0, 0,  1, 1, 1, 0, 4'h0, 0, 0, 0, 4'h0, 8'h00, 0, 0, 0)); // fetch JZ
        vecs.push_back(mkv(0, 8'h00, 0, 0, 0,  0, 0, 0, 0, 4'h0, 0, 0, 0, 4'h3, 8'h63, 0, 0, 0));
        vecs.push_back(mkv(0, 8'h40, 1, 1, 0,  1, 0, 0, 1, 4'h0, 0, 0, 0, 4'h3, 8'h63, 0, 0, 0)); // JZ taken
        vecs.push_back(mkv(0, 8'h63, 1, 0, 0,  1, 1, 1, 0, 4'h0, 0, 0, 0, 4'h3, 8'h63, 0, 0, 0));
        vecs.push_back(mkv(0, 8'h00, 0, 0, 0,  0, 0, 0, 0, 4'h0, 0, 0, 0, 4'h3, 8'h63, 0, 0, 0));
        vecs.push_back(mkv(0, 8'h40, 1, 0, 1,  1, 0, 1, 0, 4'h0, 0, 0, 0, 4'h3, 8'h63, 0, 0, 0)); // JZ not taken
        vecs.push_back(mkv(0, 8'h7A, 1, 0, 0,  1, 1, 1, 0, 4'h0, 0, 0, 0, 4'h3, 8'h63, 0, 0, 0)); // fetch JC
        vecs.push_back(mkv(0, 8'h00, 0, 0, 0,  0, 0, 0, 0, 4'h0, 0, 0, 0, 4'hA, 8'h7A, 0, 0, 0));
        vecs.push_back(mkv(0, 8'h40, 0, 0, 1,  1, 0, 0, 0, 4'h0, 0, 0, 0, 4'hA, 8'h7A, 0, 0, 0)); // operand wait
        vecs.push_back(mkv(0, 8'h40, 1, 0, 1,  1, 0, 0, 1, 4'h0, 0, 0, 0, 4'hA, 8'h7A, 0, 0, 0)); // JC taken
        vecs.push_back(mkv(0, 8'h80, 1, 0, 0,  1, 1, 1, 0, 4'h0, 0, 0, 0, 4'hA, 8'h7A, 0, 0, 0)); // fetch JMP
        vecs.push_back(mkv(0, 8'h00, 0, 0, 0,  0, 0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 8'h80, 0, 0, 0));
        vecs.push_back(mkv(0, 8'h33, 1, 0, 0,  1, 0, 0, 1, 4'h0, 0, 0, 0, 4'h0, 8'h80, 0, 0, 0)); // JMP taken
        vecs.push_back(mkv(0, 8'hB2, 0, 0, 0,  1, 0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 8'h80, 0, 0, 0)); // fetch wait 1
        vecs.push_back(mkv(0, 8'hB2, 0, 0, 0,  1, 0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 8'h80, 0, 0, 0)); // fetch wait 2
        vecs.push_back(mkv(0, 8'hB2, 0, 0, 0,  1, 0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 8'h80, 0, 0, 0)); // fetch wait 3
        vecs.push_back(mkv(0, 8'hB2, 1, 0, 0,  1, 1, 1, 0, 4'h0, 0, 0, 0, 4'h0, 8'h80, 0, 0, 0)); // accept SHL
        vecs.push_back(mkv(0, 8'h00, 0, 0, 0,  0, 0, 0, 0, 4'h0, 0, 0, 0, 4'h2, 8'hB2, 0, 0, 0));
        vecs.push_back(mkv(0, 8'h00, 0, 0, 0,  0, 0, 0, 0, 4'hB, 1, 1, 0, 4'h2, 8'hB2, 0, 0, 0)); // exec SHL
        vecs.push_back(mkv(0, 8'h25, 1, 0, 0,  1, 1, 1, 0, 4'h0, 0, 0, 0, 4'h2, 8'hB2, 0, 0, 0)); // fetch SUB
        vecs.push_back(mkv(0, 8'h00, 0, 0, 0,  0, 0, 0, 0, 4'h0, 0, 0, 0, 4'h5, 8'h25, 0, 0, 0));
        vecs.push_back(mkv(1, 8'h00, 1, 0, 0,  0, 0, 0, 0, 4'h0, 0, 0, 0, 4'h5, 8'h25, 0, 0, 0)); // rst in EXEC
        vecs.push_back(mkv(0, 8'h00, 0, 0, 0,  1, 0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 8'h00, 0, 0, 0)); // back in FETCH
        vecs.push_back(mkv(0, 8'h9C, 1, 0, 0,  1, 1, 1, 0, 4'h0, 0, 0, 0, 4'h0, 8'h00, 0, 0, 0)); // fetch illegal
        vecs.push_back(mkv(0, 8'h00, 0, 0, 0,  0, 0, 0, 0, 4'h0, 0, 0, 0, 4'hC, 8'h9C, 1, 0, 0)); // decode illegal
`ifdef ILLEGAL_TRAP_EN
        vecs.push_back(mkv(0, 8'h00, 0, 0, 0,  0, 0, 0, 0, 4'h0, 0, 0, 0, 4'hC, 8'h9C, 1, 0, 1)); // trapped
        vecs.push_back(mkv(0, 8'h15, 1, 0, 0,  0, 0, 0, 0, 4'h0, 0, 0, 0, 4'hC, 8'h9C, 1, 0, 1)); // inputs ignored
`else
        vecs.push_back(mkv(0, 8'h00, 0, 0, 0,  1, 0, 0, 0, 4'h0, 0, 0, 0, 4'hC, 8'h9C, 0, 0, 0)); // treated as NOP
        vecs.push_back(mkv(0, 8'h15, 1, 0, 0,  1, 1, 1, 0, 4'h0, 0, 0, 0, 4'hC, 8'h9C, 0, 0, 0)); // next fetch
`endif

        // Bring the DUT out of an unknown power-up state.
        step(1, 8'h00, 0, 0, 0);
        step(1, 8'h00, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].instr, vecs[i].rdy, vecs[i].z, vecs[i].c);
            check($sformatf("vec[%0d]", i), 32'(outs()), 32'(vecs[i].exp));
        end

        // HALT opcode: stays halted with memory idle regardless of inputs.
        step(1, 8'h00, 0, 0, 0);
        step(0, 8'hF0, 1, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        check("halt_decode_not_halted", 32'(halted), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(0, 8'h15, 1, 1, 1);
            check($sformatf("halt_op_halted[%0d]", i), 32'(halted), 32'd1);
            check($sformatf("halt_op_strobes[%0d]", i),
                  32'({mem_rd, ir_load, pc_inc, pc_load, acc_load, flag_load, reg_we}), 32'd0);
        end
        check("halt_op_no_bus_err", 32'(bus_err), 32'd0);

        // FETCH timeout: 16 wait cycles with mem_rd held, then HALT + bus_err.
        step(1, 8'h00, 0, 0, 0);
        for (int i = 1; i <= 16; i++) begin
            step(0, 8'h00, 0, 0, 0);
            check($sformatf("to_wait_mem_rd[%0d]", i), 32'({mem_rd, halted, bus_err}), 32'b100);
        end
        step(0, 8'h00, 0, 0, 0);
        check("to_fetch_halt", 32'({mem_rd, halted, bus_err}), 32'b011);
        step(0, 8'h15, 1, 0, 0);
        check("to_fetch_ignored", 32'({mem_rd, ir_load, pc_inc, halted, bus_err}), 32'b00011);

        // bus_err is cleared only by reset.
        step(1, 8'h00, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        check("to_rst_clears", 32'({mem_rd, halted, bus_err}), 32'b100);

        // mem_ready on the 16th wait cycle is accepted normally.
        step(1, 8'h00, 0, 0, 0);
        for (int i = 1; i <= 15; i++) begin
            step(0, 8'h00, 0, 0, 0);
        end
        step(0, 8'h00, 1, 0, 0);
        check("edge_accept", 32'({mem_rd, ir_load, pc_inc, halted, bus_err}), 32'b11100);
        step(0, 8'h00, 0, 0, 0);
        check("edge_no_halt", 32'({halted, bus_err}), 32'b00);

        // OPER timeout after the wait counter restarts on OPER entry.
        step(1, 8'h00, 0, 0, 0);
        step(0, 8'h80, 1, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        for (int i = 1; i <= 16; i++) begin
            step(0, 8'h00, 0, 0, 0);
        end
        check("to_oper_last_wait", 32'({mem_rd, pc_load, pc_inc, halted}), 32'b1000);
        step(0, 8'h44, 1, 0, 0);
        check("to_oper_halt", 32'({mem_rd, pc_load, pc_inc, halted, bus_err}), 32'b00011);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
